// File: rtl/regfile_dump_reader_if.sv
// Streaming beat interface carrying register-dump words from the reader to a
// debug/trace consumer.
interface regfile_dump_reader_if #(
    parameter int AW = 5
);
    logic [31:0]   dout;
    logic [AW-1:0] dout_idx;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;

    modport master (
        output dout,
        output dout_idx,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_idx,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Streams a contiguous block of register-file words out over valid/ready.
// Optional build macro REGDUMP_X0_ZERO_EN forces the word at address 0 to zero.
module regfile_dump_reader #(
    parameter  int SIZE      = 32,
    parameter  int BUF_DEPTH = 4,
    localparam int AW        = $clog2(SIZE)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           count,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         rd_addr,
    input  logic [31:0]           rd_data,
    regfile_dump_reader_if.master dout_if
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 3);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   buf_data [BUF_DEPTH];
    logic [AW-1:0] buf_idx  [BUF_DEPTH];
    logic          buf_last [BUF_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] committed;

    logic          iss_v, iss_last;
    logic          dat_v, dat_last;
    logic [AW-1:0] dat_idx;
    logic [AW-1:0] next_addr;
    logic [AW:0]   remaining;

    logic          head_valid, pop, accept, zero_req, issue_now, finish;
    logic [31:0]   push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (occ != '0);
    assign pop        = head_valid && dout_if.dout_ready;
    assign finish     = pop && buf_last[rptr];
    assign accept     = (state == IDLE) && start && (count != '0);
    assign zero_req   = (state == IDLE) && start && (count == '0);

    // Buffer slots plus reads still in the memory pipeline; a new read only
    // goes out if its word is guaranteed a slot when it lands.
    assign committed  = occ + CW'(dat_v) + CW'(iss_v) - CW'(pop);
    assign issue_now  = (state == ISSUE) && (remaining != '0) &&
                        (committed < CW'(BUF_DEPTH));

`ifdef REGDUMP_X0_ZERO_EN
    assign push_data = (dat_idx == '0) ? 32'h0 : rd_data;
`else
    assign push_data = rd_data;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (remaining == '0) state_nxt = DRAIN;
            DRAIN:   if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            done      <= 1'b0;
            rd_addr   <= '0;
            next_addr <= '0;
            remaining <= '0;
            iss_v     <= 1'b0;
            iss_last  <= 1'b0;
            dat_v     <= 1'b0;
            dat_last  <= 1'b0;
            dat_idx   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
        end else begin
            state <= state_nxt;
            done  <= zero_req || ((state != IDLE) && finish);
            iss_v <= accept || issue_now;

            if (accept) begin
                rd_addr   <= base_addr;
                next_addr <= base_addr + 1'b1;
                remaining <= count - 1'b1;
                iss_last  <= (count == 1);
            end else if (issue_now) begin
                rd_addr   <= next_addr;
                next_addr <= next_addr + 1'b1;
                remaining <= remaining - 1'b1;
                iss_last  <= (remaining == 1);
            end

            dat_v    <= iss_v;
            dat_last <= iss_last;
            dat_idx  <= rd_addr;

            if (dat_v) wptr <= ptr_inc(wptr);
            if (pop)   rptr <= ptr_inc(rptr);
            occ <= occ + CW'(dat_v) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (dat_v) begin
            buf_data[wptr] <= push_data;
            buf_idx[wptr]  <= dat_idx;
            buf_last[wptr] <= dat_last;
        end
    end

    assign busy               = (state != IDLE);
    assign dout_if.dout_valid = head_valid;
    assign dout_if.dout       = head_valid ? buf_data[rptr] : '0;
    assign dout_if.dout_idx   = head_valid ? buf_idx[rptr]  : '0;
    assign dout_if.dout_last  = head_valid && buf_last[rptr];

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: table-driven dumps, directed
// backpressure/reset/x0 sequences and random dumps against a beat-queue model.
module tb_regfile_dump_reader;

    localparam int SIZE = 32;
    localparam int R_ALWAYS = 0, R_RANDOM = 1, R_ALT = 2, R_HOLD0 = 3;

    typedef struct {
        int base;
        int cnt;
        int ready_mode;
        int exp_done_lat;
        int exp_busy;
        int exp_first;
    } vec_t;

    typedef struct {
        logic [4:0] idx;
        logic       last;
    } beat_t;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    regfile_dump_reader_if #(.AW(5)) dout_if ();

    regfile_dump_reader #(.SIZE(SIZE), .BUF_DEPTH(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dout_if   (dout_if)
    );

    logic [31:0] mem [SIZE];
    logic [31:0] seen_data [SIZE];
    beat_t       exp_q [$];
    vec_t        vecs [6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = R_ALWAYS;
    int beat_cnt = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous-read memory: data appears the cycle after the address.
    always @(posedge CLK) rd_data <= mem[rd_addr];

    initial begin
        dout_if.dout_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                R_RANDOM: dout_if.dout_ready = 1'($urandom_range(0, 1));
                R_ALT:    dout_if.dout_ready = ~dout_if.dout_ready;
                R_HOLD0:  dout_if.dout_ready = 1'b0;
                default:  dout_if.dout_ready = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expData(input logic [4:0] idx);
`ifdef REGDUMP_X0_ZERO_EN
        if (idx == 5'd0) return 32'h0;
`endif
        return mem[idx];
    endfunction

    // Beat monitor: every handshake is checked against the model queue, and
    // a stalled beat must stay put until it is taken.
    initial begin
        logic        prev_valid, prev_ready, prev_rst;
        logic [38:0] prev_vec, cur_vec;
        beat_t       e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_rst   = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge CLK);
            cur_vec = {dout_if.dout_valid, dout_if.dout_last, dout_if.dout_idx, dout_if.dout};
            if (prev_valid && !prev_ready && prev_rst && RST_N)
                checkOutput("hold_stable", 64'(cur_vec), 64'(prev_vec));
            if (RST_N && dout_if.dout_valid && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            if (RST_N && dout_if.dout_valid && dout_if.dout_ready) begin
                beat_cnt++;
                seen_data[dout_if.dout_idx] = dout_if.dout;
                if (exp_q.size() == 0) begin
                    checkOutput("extra_beat", 64'(dout_if.dout_idx), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_idx", 64'(dout_if.dout_idx), 64'(e.idx));
                    checkOutput("beat_data", 64'(dout_if.dout), 64'(expData(e.idx)));
                    checkOutput("beat_last", 64'(dout_if.dout_last), 64'(e.last));
                end
            end
            if (RST_N && done) done_cnt++;
            prev_valid = dout_if.dout_valid;
            prev_ready = dout_if.dout_ready;
            prev_rst   = RST_N;
            prev_vec   = cur_vec;
        end
    end

    task automatic applyStimulus(input int base, input int cnt);
        @(posedge CLK);
        #1;
        start           = 1'b1;
        base_addr       = 5'(base);
        count           = 6'(cnt);
        start_cyc       = cyc;
        first_valid_cyc = -1;
        beat_cnt        = 0;
        for (int k = 0; k < cnt; k++)
            exp_q.push_back('{idx: 5'((base + k) % SIZE), last: (k == cnt - 1)});
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int done_cyc, output int busy_cycles);
        done_cyc    = -1;
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done) begin
                done_cyc = cyc;
                checkOutput("busy_at_done", 64'(busy), 64'd0);
                break;
            end
            if (busy) busy_cycles++;
        end
        if (done_cyc < 0) checkOutput("done_timeout", 64'd0, 64'd1);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dcyc, bcyc, b0, dc0, base, cnt;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        RST_N     = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = 32'(i) * 32'h01010101;
        for (int i = 0; i < SIZE; i++) seen_data[i] = '0;

        vecs[0] = '{0,  32, R_ALWAYS, 35, 34, 3};
        vecs[1] = '{30, 4,  R_ALWAYS, 7,  6,  3};
        vecs[2] = '{0,  0,  R_ALWAYS, 1,  0,  -1};
        vecs[3] = '{7,  1,  R_ALWAYS, 4,  3,  3};
        vecs[4] = '{12, 8,  R_RANDOM, -2, -2, -2};
        vecs[5] = '{31, 2,  R_ALWAYS, 5,  4,  3};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_valid", 64'(dout_if.dout_valid), 64'd0);
        checkOutput("reset_rd_addr", 64'(rd_addr), 64'd0);
        checkOutput("reset_dout", 64'(dout_if.dout), 64'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        for (int v = 0; v < 6; v++) begin
            ready_mode = vecs[v].ready_mode;
            applyStimulus(vecs[v].base, vecs[v].cnt);
            waitDone(400, dcyc, bcyc);
            checkOutput("vec_beats", 64'(beat_cnt), 64'(vecs[v].cnt));
            checkOutput("vec_queue_empty", 64'(exp_q.size()), 64'd0);
            if (vecs[v].exp_done_lat != -2)
                checkOutput("vec_done_latency", 64'(dcyc - start_cyc), 64'(vecs[v].exp_done_lat));
            if (vecs[v].exp_busy != -2)
                checkOutput("vec_busy_cycles", 64'(bcyc), 64'(vecs[v].exp_busy));
            if (vecs[v].exp_first == -1)
                checkOutput("vec_no_valid", 64'(first_valid_cyc), 64'(-1));
            else if (vecs[v].exp_first != -2)
                checkOutput("vec_first_valid", 64'(first_valid_cyc - start_cyc), 64'(vecs[v].exp_first));
        end

        // Backpressure with an ignored second start while busy.
        ready_mode = R_ALT;
        applyStimulus(4, 8);
        repeat (6) @(posedge CLK);
        #1;
        start     = 1'b1;
        base_addr = 5'd20;
        count     = 6'd3;
        @(posedge CLK);
        #1;
        start      = 1'b0;
        ready_mode = R_HOLD0;
        repeat (10) @(negedge CLK);
        #1;
        checkOutput("stall_valid", 64'(dout_if.dout_valid), 64'd1);
        checkOutput("stall_partial", 64'(beat_cnt < 8), 64'd1);
        ready_mode = R_ALWAYS;
        waitDone(100, dcyc, bcyc);
        checkOutput("bp_beats", 64'(beat_cnt), 64'd8);
        repeat (8) @(negedge CLK);
        #1;
        checkOutput("bp_no_extra", 64'(beat_cnt), 64'd8);
        checkOutput("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a 16-word dump.
        applyStimulus(0, 16);
        for (int i = 0; i < 100 && beat_cnt < 5; i++) begin
            @(negedge CLK);
            #1;
        end
        checkOutput("rst_reached_5", 64'(beat_cnt >= 5), 64'd1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK);
        exp_q.delete();
        dc0 = done_cnt;
        @(negedge CLK);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(dout_if.dout_valid), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        b0 = beat_cnt;
        repeat (10) @(negedge CLK);
        #1;
        checkOutput("rst_stale_beats", 64'(beat_cnt - b0), 64'd0);
        checkOutput("rst_no_done", 64'(done_cnt - dc0), 64'd0);
        applyStimulus(0, 2);
        waitDone(50, dcyc, bcyc);
        checkOutput("rst_fresh_beats", 64'(beat_cnt), 64'd2);
        checkOutput("rst_fresh_latency", 64'(dcyc - start_cyc), 64'd5);

        // Address 0 handling.
        mem[0] = 32'hDEADBEEF;
        seen_data[0] = 32'h12345678;
        applyStimulus(0, 2);
        waitDone(50, dcyc, bcyc);
`ifdef REGDUMP_X0_ZERO_EN
        checkOutput("x0_word", 64'(seen_data[0]), 64'h0);
`else
        checkOutput("x0_word", 64'(seen_data[0]), 64'hDEADBEEF);
`endif
        checkOutput("x1_word", 64'(seen_data[1]), 64'h01010101);

        // Random dumps.
        for (int r = 0; r < 10; r++) begin
            base = int'($urandom_range(0, SIZE - 1));
            cnt  = int'($urandom_range(1, SIZE));
            ready_mode = int'($urandom_range(0, 2));
            applyStimulus(base, cnt);
            waitDone(400, dcyc, bcyc);
            checkOutput("rand_beats", 64'(beat_cnt), 64'(cnt));
            checkOutput("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Sequential reader for the CPU register-file dual-port memory. It drives the memory's synchronous read port and streams a contiguous block of registers out over a valid/ready interface, with index and last-beat tagging. It is used for debug register dumps and context save, and sits between the register file read port and a debug/trace consumer. An internal credit-controlled buffer absorbs the one-cycle read latency so that backpressure never drops or duplicates a word.

Parameters:
SIZE, 32, number of 32-bit words in the attached memory; must be a power of two.
AW, $clog2(SIZE), address width (derived, not overridden).
BUF_DEPTH, 4, output buffer entries; must be ≥3 for full throughput.

Ports:
CLK  input  1  clock; all logic is rising-edge.
RST_N  input  1  synchronous, active-low reset.
start  input  1  request a dump; sampled only while idle.
base_addr  input  AW  first word address.
count  input  AW+1  number of words, 0..SIZE.
busy  output  1  dump in progress.
done  output  1  one-cycle pulse when a dump completes.
rd_addr  output  AW  to the memory read-address input.
rd_data  input  32  memory read data, valid the cycle after rd_addr.
dout  output  32  streamed word.
dout_idx  output  AW  memory address of dout.
dout_valid  output  1  beat valid.
dout_ready  input  1  consumer accepts the beat.
dout_last  output  1  final beat of the dump; qualified by dout_valid.

Behaviour:
- Reset (RST_N=0 at a clock edge): all outputs go to 0, the FSM returns to IDLE, the buffer is flushed, and the in-flight read is discarded. Applies mid-dump; the aborted dump produces no done pulse.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 with count≠0 → latch base_addr/count, go to ISSUE, busy=1 from the next cycle.
  - start=1 with count=0 → stay in IDLE, busy stays 0, done=1 for one cycle in the next cycle.
  - start while busy=1 is ignored.
- ISSUE:
  - rd_addr is registered and equals the current issue address.
  - A read is issued in a cycle when (buffer occupancy + in-flight reads) < BUF_DEPTH.
  - The issue address increments modulo SIZE, wrapping SIZE-1 → 0.
  - After count issues → DRAIN.
- In-flight data: rd_data is captured into the buffer the cycle after its issue, tagged with its address and a last flag (set on the count-th issue).
- DRAIN: wait until the buffer is empty and the last beat has handshaked.
- Completion: the beat with dout_last=1 handshakes in cycle n → done=1 and busy=0 in cycle n+1, FSM back to IDLE. A new start is accepted in cycle n+1.
- Output handshake:
  - dout, dout_idx and dout_last come from the buffer head and are held stable while dout_valid=1 and dout_ready=0.
  - dout_valid never drops without a handshake.
  - Beats arrive in strictly ascending address order, modulo SIZE.
- Latency and throughput:
  - start high in cycle t, dout_ready held at 1 → first rd_addr in t+1, first dout_valid in t+3.
  - One beat per cycle thereafter; final beat in t+2+count; done in t+3+count.
- rd_addr holds its last value when no read is issued. The memory has no read enable, so extra reads are harmless.

Optional Feature:
REGDUMP_X0_ZERO_EN:
- Defined: a beat whose dout_idx is 0 always carries dout=32'h0, regardless of rd_data (RISC-V x0 semantics). Timing is unchanged.
- Undefined: dout always equals the memory contents.

Test Plan:
1. SIZE=32, mem[i]=i*32'h01010101; start base=0 count=32 at t, ready=1 → dout_valid t+3..t+34; dout_idx 0..31; dout[5]=32'h05050505; dout_last only at idx 31; done t+35; busy 1 over t+1..t+34.
2. Backpressure: base=4 count=8, dout_ready alternating 1/0, then held 0 for 10 cycles:
   - exactly 8 beats, idx 4..11, no loss or duplication;
   - outputs stable while stalled;
   - at most BUF_DEPTH reads outstanding;
   - a second start during busy is ignored.
3. Wrap: base=30 count=4 → dout_idx 30,31,0,1 with matching data; dout_last on idx 1.
4. count=0 start → done pulse exactly one cycle later; busy and dout_valid never assert.
5. RST_N=0 after 5 beats of a 16-word dump:
   - the next cycle has busy, dout_valid and done all 0;
   - no stale beat appears after reset releases;
   - a fresh dump base=0 count=2 then completes normally.
6. mem[0]=32'hDEADBEEF, dump base=0 count=2 → dout[0]=0 with REGDUMP_X0_ZERO_EN defined, 32'hDEADBEEF without it; dout[1] equals mem[1] in both builds.
